// File: rtl/qspi_target_fsm.sv
// qspi_target_fsm
//   QSPI target (flash responder). Oversamples the QSPI pins on clk, decodes
//   opcode / address / alt / dummy phases and, for Quad I/O Fast Read,
//   streams nibbles from a synchronous byte memory (data valid 1 clk after
//   mem_addr).
// Ports
//   clk, reset          system clock (>= 4x SCLK), synchronous active-high reset
//   qspi_sclk/cs_n/io_in asynchronous QSPI pins (mode 0)
//   qspi_io_out/io_oe   nibble driven on IO[3:0] and its output enable
//   mem_addr/mem_rdata  byte memory read port
//   current_phase, busy status, registered from state (1 clk lag)
//   cmd_valid           1-clk pulse when the address phase completes
//   cmd_opcode/addr/alt captured command fields
//
// state  | meaning
// IDLE   | waiting for a CS_N fall
// INSTR  | shifting 8 opcode bits on io[0]
// ADDR   | shifting 6 address nibbles
// ALT    | shifting 2 mode/alt nibbles
// DUMMY  | counting DUMMY_CYCLES rises, never driving
// DATA   | driving memory nibbles on SCLK falls
// IGNORE | unsupported opcode, waits for CS_N rise
module qspi_target_fsm #(
  parameter int          DUMMY_CYCLES = 4,
  parameter logic [7:0]  OPCODE_QREAD = 8'hEB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        qspi_sclk,
  input  logic        qspi_cs_n,
  input  logic [3:0]  qspi_io_in,
  output logic [3:0]  qspi_io_out,
  output logic        qspi_io_oe,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [2:0]  current_phase,
  output logic        busy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [23:0] cmd_addr,
  output logic [7:0]  cmd_alt
);

  localparam logic [2:0] PHASE_IDLE    = 3'd0;
  localparam logic [2:0] PHASE_INSTR   = 3'd1;
  localparam logic [2:0] PHASE_ADDRESS = 3'd2;
  localparam logic [2:0] PHASE_ALT     = 3'd3;
  localparam logic [2:0] PHASE_DUMMY   = 3'd4;
  localparam logic [2:0] PHASE_DATA    = 3'd5;

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_ADDR, S_ALT, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [23:0] shreg;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic [3:0] io_s1, io_s2;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [23:0] shift_single, shift_quad;

  // SCLK edges only count while the synced chip select is low
  assign sclk_rise = sclk_s2 & ~sclk_s3 & ~cs_s2;
  assign sclk_fall = ~sclk_s2 & sclk_s3 & ~cs_s2;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;

  assign shift_single = {shreg[22:0], io_s2[0]};
  assign shift_quad   = {shreg[19:0], io_s2};

  function automatic logic [2:0] phase_of(input state_t s);
    case (s)
      S_INSTR: phase_of = PHASE_INSTR;
      S_ADDR:  phase_of = PHASE_ADDRESS;
      S_ALT:   phase_of = PHASE_ALT;
      S_DUMMY: phase_of = PHASE_DUMMY;
      S_DATA:  phase_of = PHASE_DATA;
      default: phase_of = PHASE_IDLE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1       <= 1'b0;
      sclk_s2       <= 1'b0;
      sclk_s3       <= 1'b0;
      cs_s1         <= 1'b1;
      cs_s2         <= 1'b1;
      cs_s3         <= 1'b1;
      io_s1         <= 4'h0;
      io_s2         <= 4'h0;
      state         <= S_IDLE;
      bit_cnt       <= 4'd0;
      shreg         <= 24'h0;
      qspi_io_out   <= 4'h0;
      qspi_io_oe    <= 1'b0;
      mem_addr      <= 24'h0;
      current_phase <= PHASE_IDLE;
      busy          <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_opcode    <= 8'h0;
      cmd_addr      <= 24'h0;
      cmd_alt       <= 8'h0;
    end else begin
      sclk_s1 <= qspi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= qspi_cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      io_s1   <= qspi_io_in;
      io_s2   <= io_s1;

      current_phase <= phase_of(state);
      busy          <= (state != S_IDLE);
      cmd_valid     <= 1'b0;

      if (cs_rise) begin
        state      <= S_IDLE;
        bit_cnt    <= 4'd0;
        qspi_io_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state   <= S_INSTR;
              bit_cnt <= 4'd0;
            end
          end
          S_INSTR: begin
            if (sclk_rise) begin
              shreg   <= shift_single;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                cmd_opcode <= shift_single[7:0];
                bit_cnt    <= 4'd0;
                state      <= (shift_single[7:0] == OPCODE_QREAD) ? S_ADDR : S_IGNORE;
              end
            end
          end
          S_ADDR: begin
            if (sclk_rise) begin
              shreg   <= shift_quad;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd5) begin
                cmd_addr  <= shift_quad;
                mem_addr  <= shift_quad;
                cmd_valid <= 1'b1;
                bit_cnt   <= 4'd0;
                state     <= S_ALT;
              end
            end
          end
          S_ALT: begin
            if (sclk_rise) begin
              shreg   <= shift_quad;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd1) begin
                cmd_alt <= shift_quad[7:0];
                bit_cnt <= 4'd0;
                state   <= S_DUMMY;
              end
            end
          end
          S_DUMMY: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == DUMMY_LAST) begin
                bit_cnt <= 4'd0;
                state   <= S_DATA;
              end
            end
          end
          S_DATA: begin
            // bit_cnt[0] selects the nibble: 0 = high (first fall), 1 = low
            if (sclk_fall) begin
              qspi_io_oe <= 1'b1;
              bit_cnt    <= {3'b000, ~bit_cnt[0]};
              if (!bit_cnt[0]) begin
                qspi_io_out <= mem_rdata[7:4];
              end else begin
                qspi_io_out <= mem_rdata[3:0];
                mem_addr    <= mem_addr + 24'd1;
              end
            end
          end
          S_IGNORE: begin
            qspi_io_oe <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_target_fsm.sv
// tb_qspi_target_fsm
//   Directed bench for qspi_target_fsm: acts as the QSPI host (SCLK half
//   period = 8 clk), models the byte memory as mem[n] = n[7:0] ^ 8'h5A with
//   one clk of read latency, and checks status, captured fields and the
//   nibbles returned on IO.
module tb_qspi_target_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        qspi_sclk;
  logic        qspi_cs_n;
  logic [3:0]  qspi_io_in;
  logic [3:0]  qspi_io_out;
  logic        qspi_io_oe;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [2:0]  current_phase;
  logic        busy;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_alt;

  int tests = 0;
  int fails = 0;
  int valid_pulses = 0;
  bit oe_seen = 1'b0;
  logic [3:0] seen;
  logic       seen_oe;

  always #5 clk = ~clk;

  qspi_target_fsm #(.DUMMY_CYCLES(4), .OPCODE_QREAD(8'hEB)) dut (
    .clk(clk), .reset(reset),
    .qspi_sclk(qspi_sclk), .qspi_cs_n(qspi_cs_n), .qspi_io_in(qspi_io_in),
    .qspi_io_out(qspi_io_out), .qspi_io_oe(qspi_io_oe),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .current_phase(current_phase), .busy(busy), .cmd_valid(cmd_valid),
    .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_alt(cmd_alt)
  );

  always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

  always @(negedge clk) begin
    if (cmd_valid) valid_pulses++;
    if (qspi_io_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK period: fall + drive IO, low half, rise (host samples IO here), high half
  task automatic cyc(input logic [3:0] v);
    qspi_sclk  = 1'b0;
    qspi_io_in = v;
    clk_wait(8);
    qspi_sclk = 1'b1;
    seen      = qspi_io_out;
    seen_oe   = qspi_io_oe;
    clk_wait(8);
  endtask

  task automatic send_single(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]});
  endtask

  task automatic send_quad(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(v[i*4 +: 4]);
  endtask

  task automatic start_txn();
    qspi_cs_n = 1'b0;
    clk_wait(8);
  endtask

  task automatic end_txn();
    qspi_cs_n = 1'b1;
    clk_wait(8);
    qspi_sclk = 1'b0;
    clk_wait(8);
  endtask

  task automatic header(input logic [23:0] addr, input logic [7:0] alt);
    send_single(8'hEB);
    send_quad(addr, 6);
    send_quad({16'h0, alt}, 2);
    for (int i = 0; i < 4; i++) cyc(4'h0);
  endtask

  initial begin
    reset      = 1'b1;
    qspi_cs_n  = 1'b0;
    qspi_sclk  = 1'b0;
    qspi_io_in = 4'h0;

    // Reset held for 3 clk with SCLK toggling and CS_N low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      qspi_sclk = ~qspi_sclk;
    end
    chk("reset_phase", 32'(current_phase), 32'd0);
    chk("reset_oe", 32'(qspi_io_oe), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_opcode", 32'(cmd_opcode), 32'd0);
    qspi_cs_n = 1'b1;
    qspi_sclk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clk_wait(8);
    chk("reset_no_valid", 32'(valid_pulses), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic read at 0x012345, alt 0xA5
    start_txn();
    chk("instr_phase", 32'(current_phase), 32'd1);
    send_single(8'hEB);
    chk("addr_phase", 32'(current_phase), 32'd2);
    send_quad(24'h012345, 6);
    chk("basic_valid_cnt", 32'(valid_pulses), 32'd1);
    chk("basic_addr", 32'(cmd_addr), 32'h012345);
    chk("basic_mem_addr", 32'(mem_addr), 32'h012345);
    chk("basic_opcode", 32'(cmd_opcode), 32'hEB);
    chk("alt_phase", 32'(current_phase), 32'd3);
    send_quad(24'h0000A5, 2);
    chk("basic_alt", 32'(cmd_alt), 32'hA5);
    chk("dummy_phase", 32'(current_phase), 32'd4);
    for (int i = 0; i < 4; i++) cyc(4'h0);
    chk("data_phase", 32'(current_phase), 32'd5);
    chk("dummy_no_oe", 32'(qspi_io_oe), 32'd0);
    cyc(4'h0); chk("basic_n0", 32'(seen), 32'h1); chk("basic_oe", 32'(seen_oe), 32'd1);
    cyc(4'h0); chk("basic_n1", 32'(seen), 32'hF);
    cyc(4'h0); chk("basic_n2", 32'(seen), 32'h1);
    cyc(4'h0); chk("basic_n3", 32'(seen), 32'hC);
    chk("basic_mem_addr_end", 32'(mem_addr), 32'h012347);
    end_txn();
    chk("end_phase", 32'(current_phase), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_oe", 32'(qspi_io_oe), 32'd0);
    chk("basic_valid_once", 32'(valid_pulses), 32'd1);

    // Address wrap at 0xFFFFFF
    start_txn();
    header(24'hFFFFFF, 8'h00);
    cyc(4'h0); chk("wrap_n0", 32'(seen), 32'hA);
    chk("wrap_addr0", 32'(mem_addr), 32'hFFFFFF);
    cyc(4'h0); chk("wrap_n1", 32'(seen), 32'h5);
    chk("wrap_addr1", 32'(mem_addr), 32'h000000);
    cyc(4'h0); chk("wrap_n2", 32'(seen), 32'h5);
    cyc(4'h0); chk("wrap_n3", 32'(seen), 32'hA);
    end_txn();

    // Unsupported opcode 0x03 followed by 40 SCLK cycles
    oe_seen = 1'b0;
    start_txn();
    send_single(8'h03);
    for (int i = 0; i < 40; i++) cyc(4'hF);
    chk("ign_opcode", 32'(cmd_opcode), 32'h03);
    chk("ign_phase", 32'(current_phase), 32'd0);
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_no_oe", 32'(oe_seen), 32'd0);
    chk("ign_no_valid", 32'(valid_pulses), 32'd2);
    end_txn();
    chk("ign_end_busy", 32'(busy), 32'd0);

    // Abort after 3 address nibbles
    start_txn();
    send_single(8'hEB);
    send_quad(24'h000123, 3);
    qspi_cs_n = 1'b1;
    clk_wait(4);
    chk("abort_addr_phase", 32'(current_phase), 32'd0);
    chk("abort_addr_busy", 32'(busy), 32'd0);
    chk("abort_addr_keep", 32'(cmd_addr), 32'hFFFFFF);
    chk("abort_addr_valid", 32'(valid_pulses), 32'd2);
    qspi_sclk = 1'b0;
    clk_wait(8);

    // Abort in DATA after 2 bytes, then a clean read at 0x000010
    start_txn();
    header(24'h000200, 8'h3C);
    for (int i = 0; i < 4; i++) cyc(4'h0);
    chk("abort_data_oe_on", 32'(qspi_io_oe), 32'd1);
    qspi_cs_n = 1'b1;
    clk_wait(3);
    chk("abort_data_oe_off", 32'(qspi_io_oe), 32'd0);
    clk_wait(5);
    qspi_sclk = 1'b0;
    clk_wait(8);
    start_txn();
    header(24'h000010, 8'h81);
    chk("next_addr", 32'(cmd_addr), 32'h000010);
    chk("next_alt", 32'(cmd_alt), 32'h81);
    chk("next_valid", 32'(valid_pulses), 32'd4);
    cyc(4'h0); chk("next_n0", 32'(seen), 32'h4);
    cyc(4'h0); chk("next_n1", 32'(seen), 32'hA);

    // Reset mid-transfer returns everything to reset values
    @(negedge clk);
    reset = 1'b1;
    clk_wait(2);
    chk("midrst_phase", 32'(current_phase), 32'd0);
    chk("midrst_oe", 32'(qspi_io_oe), 32'd0);
    chk("midrst_addr", 32'(cmd_addr), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    qspi_cs_n = 1'b1;
    qspi_sclk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clk_wait(8);
    chk("midrst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
